// File: rtl/cnn_window_fetch.sv
// cnn_window_fetch: KxK sliding-window read sequencer between the pixel RAM and cnn_core.
// It waits until every pixel of the current window has been written to RAM and the core is idle.
// It then issues one RAM read per window element and forwards the returned pixels, tagged first/last.
// Anchors are visited row-major. Every anchor and address step uses adders only.
module cnn_window_fetch #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ORDER  = 0,
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ADDR_W-1:0] wr_cnt,
  input  logic              core_bsy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              pix_vld,
  output logic [PIX_W-1:0]  pix,
  output logic              pix_first,
  output logic              pix_last,
  output logic              frame_done
);

  localparam int KK = K * K;
  localparam int EW = $clog2(KK + 1);
  localparam int CW = $clog2(K + 1);

  // Offset of the bottom-right element from the window anchor
  localparam logic [ADDR_W-1:0] LAST_OFF   = ADDR_W'((K - 1) * IMG_W + (K - 1));
  // Jump from the end of one window row to the start of the next
  localparam logic [ADDR_W-1:0] WRAP_STEP  = ADDR_W'(IMG_W - (K - 1));
  localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(STRIDE * IMG_W);
  localparam logic [ADDR_W-1:0] OUT_W_M1   = ADDR_W'((IMG_W - K) / STRIDE);
  localparam logic [ADDR_W-1:0] OUT_H_M1   = ADDR_W'((IMG_H - K) / STRIDE);
  localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
  localparam logic [EW-1:0]     KK_M1      = EW'(KK - 1);
  localparam logic [EW-1:0]     ONE_E      = EW'(1);
  localparam logic [CW-1:0]     K_M1       = CW'(K - 1);
  localparam logic [CW-1:0]     ONE_C      = CW'(1);

  typedef enum logic [1:0] {ST_WAIT, ST_FETCH, ST_DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] row_reg;
  logic [ADDR_W-1:0] col_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [EW-1:0]     elem_reg;
  logic [CW-1:0]     ccol_reg;
  logic              first_reg;
  logic              last_reg;

  logic [ADDR_W:0]   need_cnt;
  logic              avail;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] step_addr;
  logic [EW-1:0]     elem_next;
  logic              elem_last;
  logic              last_win;

  // Window readiness, first address of a window and next address within it
  always_comb begin
    need_cnt   = {1'b0, base_reg} + {1'b0, LAST_OFF};
    avail      = {1'b0, wr_cnt} > need_cnt;
    elem_next  = elem_reg + ONE_E;
    elem_last  = (elem_reg == KK_M1);
    last_win   = (row_reg == OUT_H_M1) && (col_reg == OUT_W_M1);
    start_addr = base_reg;
    step_addr  = mem_rd_addr;
    if (ORDER == 0) begin
      step_addr = (ccol_reg == K_M1) ? mem_rd_addr + WRAP_STEP : mem_rd_addr + ONE_A;
    end else begin
      start_addr = base_reg + LAST_OFF;
      step_addr  = (ccol_reg == K_M1) ? mem_rd_addr - WRAP_STEP : mem_rd_addr - ONE_A;
    end
  end

  // Window sequencer: wait for data and an idle core, burst K*K reads, then advance the anchor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_WAIT;
      row_reg      <= '0;
      col_reg      <= '0;
      base_reg     <= '0;
      row_base_reg <= '0;
      elem_reg     <= '0;
      ccol_reg     <= '0;
      first_reg    <= 1'b0;
      last_reg     <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_rd_addr  <= '0;
      frame_done   <= 1'b0;
    end else if (clr) begin
      state_reg    <= ST_WAIT;
      row_reg      <= '0;
      col_reg      <= '0;
      base_reg     <= '0;
      row_base_reg <= '0;
      elem_reg     <= '0;
      ccol_reg     <= '0;
      first_reg    <= 1'b0;
      last_reg     <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_rd_addr  <= '0;
      frame_done   <= 1'b0;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          frame_done <= 1'b0;
          if (avail && !core_bsy) begin
            state_reg   <= ST_FETCH;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= start_addr;
            first_reg   <= 1'b1;
            last_reg    <= (KK == 1);
            elem_reg    <= '0;
            ccol_reg    <= '0;
          end
        end
        ST_FETCH: begin
          if (elem_last) begin
            mem_rd_en <= 1'b0;
            first_reg <= 1'b0;
            last_reg  <= 1'b0;
            if (last_win) begin
              state_reg  <= ST_DONE;
              frame_done <= 1'b1;
            end else begin
              state_reg <= ST_WAIT;
              if (col_reg != OUT_W_M1) begin
                col_reg  <= col_reg + ONE_A;
                base_reg <= base_reg + STRIDE_A;
              end else begin
                col_reg      <= '0;
                row_reg      <= row_reg + ONE_A;
                row_base_reg <= row_base_reg + ROW_STRIDE;
                base_reg     <= row_base_reg + ROW_STRIDE;
              end
            end
          end else begin
            mem_rd_addr <= step_addr;
            elem_reg    <= elem_next;
            ccol_reg    <= (ccol_reg == K_M1) ? '0 : ccol_reg + ONE_C;
            first_reg   <= 1'b0;
            last_reg    <= (elem_next == KK_M1);
          end
        end
        ST_DONE: begin
          frame_done <= 1'b0;
          mem_rd_en  <= 1'b0;
        end
        default: state_reg <= ST_WAIT;
      endcase
    end
  end

  // Align the element tags with the RAM's one-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_vld   <= 1'b0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
    end else if (clr) begin
      pix_vld   <= 1'b0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
    end else begin
      pix_vld   <= mem_rd_en;
      pix_first <= mem_rd_en & first_reg;
      pix_last  <= mem_rd_en & last_reg;
    end
  end

  assign pix = mem_rd_data;

endmodule

// File: tb/tb_cnn_window_fetch.sv
// Directed bench for cnn_window_fetch. There are three instances.
// One uses the default 28x28/3x3 ascending configuration, one uses descending order, and one uses 8x8 with stride 2.
// RAM models return the parity of the address read on the previous edge.
module tb_cnn_window_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       clr, core_bsy, mem_rd_en, pix_vld, pix, pix_first, pix_last, frame_done;
  logic [9:0] wr_cnt, mem_rd_addr;
  logic       mem_rd_data = 1'b0;

  logic       r_clr, r_core_bsy, r_mem_rd_en, r_pix_vld, r_pix, r_pix_first, r_pix_last, r_frame_done;
  logic [9:0] r_wr_cnt, r_mem_rd_addr;
  logic       r_mem_rd_data = 1'b0;

  logic       s_clr, s_core_bsy, s_mem_rd_en, s_pix_vld, s_pix, s_pix_first, s_pix_last, s_frame_done;
  logic [9:0] s_wr_cnt, s_mem_rd_addr;
  logic       s_mem_rd_data = 1'b0;

  cnn_window_fetch dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_cnt(wr_cnt), .core_bsy(core_bsy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .pix_vld(pix_vld), .pix(pix), .pix_first(pix_first), .pix_last(pix_last),
    .frame_done(frame_done)
  );

  cnn_window_fetch #(.ORDER(1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .clr(r_clr), .wr_cnt(r_wr_cnt), .core_bsy(r_core_bsy),
    .mem_rd_en(r_mem_rd_en), .mem_rd_addr(r_mem_rd_addr), .mem_rd_data(r_mem_rd_data),
    .pix_vld(r_pix_vld), .pix(r_pix), .pix_first(r_pix_first), .pix_last(r_pix_last),
    .frame_done(r_frame_done)
  );

  cnn_window_fetch #(.IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .wr_cnt(s_wr_cnt), .core_bsy(s_core_bsy),
    .mem_rd_en(s_mem_rd_en), .mem_rd_addr(s_mem_rd_addr), .mem_rd_data(s_mem_rd_data),
    .pix_vld(s_pix_vld), .pix(s_pix), .pix_first(s_pix_first), .pix_last(s_pix_last),
    .frame_done(s_frame_done)
  );

  // RAM models: data = parity of the address sampled on the edge
  always @(posedge clk) begin
    mem_rd_data   <= ^mem_rd_addr;
    r_mem_rd_data <= ^r_mem_rd_addr;
    s_mem_rd_data <= ^s_mem_rd_addr;
  end

  int tests = 0;
  int fails = 0;

  // Frame statistics for the default instance
  int         rd_count = 0, vld_count = 0, first_count = 0, last_count = 0, fd_count = 0;
  int         pix_bad = 0, tag_bad = 0, idx = 0;
  logic [9:0] last_addr = '0, prev_addr = '0;
  logic       prev_en = 1'b0;
  bit         mon_on = 1'b1;
  logic [9:0] bases[$];

  // Frame statistics for the stride-2 instance
  int         s_rd_count = 0, s_fd_count = 0;
  logic [9:0] s_last_addr = '0;
  logic       s_prev_en = 1'b0;
  logic [9:0] s_bases[$];

  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      if (pix_vld) begin
        vld_count++;
        if (pix !== ^prev_addr) pix_bad++;
        if (pix_first !== (idx == 0)) tag_bad++;
        if (pix_last !== (idx == 8)) tag_bad++;
        if (pix_first) first_count++;
        if (pix_last) last_count++;
        idx = (idx == 8) ? 0 : idx + 1;
      end
      if (mem_rd_en) begin
        rd_count++;
        last_addr = mem_rd_addr;
        if (!prev_en) bases.push_back(mem_rd_addr);
      end
      if (frame_done) fd_count++;
      prev_en   = mem_rd_en;
      prev_addr = mem_rd_addr;
    end
    if (rst_n) begin
      if (s_mem_rd_en) begin
        s_rd_count++;
        s_last_addr = s_mem_rd_addr;
        if (!s_prev_en) s_bases.push_back(s_mem_rd_addr);
      end
      if (s_frame_done) s_fd_count++;
      s_prev_en = s_mem_rd_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int offs[9]  = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
  int revs[9]  = '{58, 57, 56, 30, 29, 28, 2, 1, 0};
  int s_exp[9] = '{0, 2, 4, 16, 18, 20, 32, 34, 36};
  int cyc;

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; core_bsy = 1'b0; wr_cnt = '0;
    r_clr = 1'b0; r_core_bsy = 1'b0; r_wr_cnt = '0;
    s_clr = 1'b0; s_core_bsy = 1'b0; s_wr_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_en", mem_rd_en, 0);
    check("rst_addr", mem_rd_addr, 0);
    check("rst_vld", pix_vld, 0);
    check("rst_first", pix_first, 0);
    check("rst_last", pix_last, 0);
    check("rst_done", frame_done, 0);
    rst_n = 1'b1;
    s_wr_cnt = 10'd64;

    // Window 0 not yet fully written
    wr_cnt = 10'd58;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_idle_en", mem_rd_en, 0);
    end
    wr_cnt = 10'd59;
    @(negedge clk);
    check("t2_en0", mem_rd_en, 1);
    check("t2_addr0", mem_rd_addr, offs[0]);
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      check("t2_en", mem_rd_en, 1);
      check("t2_addr", mem_rd_addr, offs[i]);
      check("t2_vld", pix_vld, 1);
      check("t2_first", pix_first, (i == 1) ? 1 : 0);
      check("t2_last", pix_last, 0);
      check("t2_pix", pix, ^offs[i-1]);
    end
    @(negedge clk);
    check("t2_gap_en", mem_rd_en, 0);
    check("t2_tail_vld", pix_vld, 1);
    check("t2_tail_last", pix_last, 1);
    check("t2_tail_pix", pix, ^offs[8]);

    // Core busy holds off the next window; busy mid-window is ignored
    core_bsy = 1'b1;
    wr_cnt = 10'd784;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_bsy_en", mem_rd_en, 0);
    end
    core_bsy = 1'b0;
    @(negedge clk);
    check("t3_en0", mem_rd_en, 1);
    check("t3_addr0", mem_rd_addr, 1);
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      if (i == 3) core_bsy = 1'b1;
      check("t3_en", mem_rd_en, 1);
      check("t3_addr", mem_rd_addr, 1 + offs[i]);
    end
    @(negedge clk);
    check("t3_gap_en", mem_rd_en, 0);
    @(negedge clk);
    check("t3_hold_en", mem_rd_en, 0);
    core_bsy = 1'b0;
    @(negedge clk);
    check("t3_w2_en", mem_rd_en, 1);
    check("t3_w2_addr", mem_rd_addr, 2);

    // Run the rest of the frame
    cyc = 0;
    while (!frame_done && cyc < 8000) begin
      @(negedge clk);
      cyc++;
    end
    check("t1_frame_done_seen", frame_done, 1);
    @(negedge clk);
    check("t1_done_pulse_len", frame_done, 0);
    check("t1_done_no_read", mem_rd_en, 0);
    repeat (3) @(negedge clk);
    #1;
    check("t1_windows", bases.size(), 676);
    check("t1_base0", bases[0], 0);
    check("t1_base1", bases[1], 1);
    check("t4_base25", bases[25], 25);
    check("t4_base26", bases[26], 28);
    check("t1_base_final", bases[675], 725);
    check("t1_reads", rd_count, 676 * 9);
    check("t1_pix_vld", vld_count, 676 * 9);
    check("t4_first_cnt", first_count, 676);
    check("t4_last_cnt", last_count, 676);
    check("t1_done_cnt", fd_count, 1);
    check("t1_last_addr", last_addr, 783);
    check("t1_pix_data", pix_bad, 0);
    check("t4_tags", tag_bad, 0);
    mon_on = 1'b0;

    // clr with data available: restart, no fetch on the clr edge
    clr = 1'b1;
    @(negedge clk);
    check("t6_clr_en", mem_rd_en, 0);
    check("t6_clr_done", frame_done, 0);
    clr = 1'b0;
    @(negedge clk);
    check("t6_restart_en", mem_rd_en, 1);
    check("t6_restart_addr", mem_rd_addr, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("t6_addr", mem_rd_addr, offs[i]);
    end
    clr = 1'b1;
    @(negedge clk);
    check("t6_abort_en", mem_rd_en, 0);
    check("t6_abort_vld", pix_vld, 0);
    clr = 1'b0;
    @(negedge clk);
    check("t6_re_en", mem_rd_en, 1);
    check("t6_re_addr", mem_rd_addr, 0);
    check("t6_re_vld", pix_vld, 0);
    @(negedge clk);
    check("t6_re_addr1", mem_rd_addr, 1);
    check("t6_re_first", pix_first, 1);

    // Stride-2 on 8x8 ran in the background since reset
    check("t6_s2_windows", s_bases.size(), 9);
    for (int i = 0; i < 9; i++) check("t6_s2_base", s_bases[i], s_exp[i]);
    check("t6_s2_reads", s_rd_count, 81);
    check("t6_s2_last_addr", s_last_addr, 54);
    check("t6_s2_done_cnt", s_fd_count, 1);

    // Async reset mid-fetch
    #2;
    rst_n = 1'b0;
    #1;
    check("async_en", mem_rd_en, 0);
    check("async_addr", mem_rd_addr, 0);
    check("async_vld", pix_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Descending element order
    r_wr_cnt = 10'd784;
    @(negedge clk);
    check("t5_en0", r_mem_rd_en, 1);
    check("t5_addr0", r_mem_rd_addr, revs[0]);
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      check("t5_addr", r_mem_rd_addr, revs[i]);
      check("t5_first", r_pix_first, (i == 1) ? 1 : 0);
    end
    @(negedge clk);
    check("t5_gap_en", r_mem_rd_en, 0);
    check("t5_last", r_pix_last, 1);
    check("t5_pix", r_pix, ^revs[8]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
